mtsp_scs_bank: RTL and testbench



---
 rtl/mtsp_scs_bank.sv | 186 ++++++++++++++++++
 tb/tb_mtsp_scs_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_scs_bank.sv
// Scratch-counter bank: NUM_SETS x LANES counters with per-lane fetch-and-op,
// returning pre-op (or global scratch counter) values with a fixed 2-cycle latency.
module mtsp_scs_bank #(
    parameter int NUM_SETS = 2,
    parameter int LANES    = 4,
    parameter int CNT_W    = 16,
    parameter int SATURATE = 0,
    parameter int SEL_W    = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MEM_nEN,
    input  logic [SEL_W-1:0]         MEM_SEL,
    input  logic [4*LANES-1:0]       MEM_OP,
    input  logic [32*LANES-1:0]      MEM_DATA,
    input  logic [CNT_W*LANES-1:0]   GSCs_DATA,
    output logic                     EW1_nEN,
    output logic [LANES-1:0]         EW1_MASK,
    output logic [32*LANES-1:0]      EW1_DATA,
    output logic [LANES-1:0]         EW1_OVF
);

    localparam logic [SEL_W:0] SET_LIMIT = (SEL_W + 1)'(NUM_SETS);

    // Returns {ovf, next_value}; ovf is the carry/borrow of the CNT_W+1 bit result.
    function automatic logic [CNT_W:0] lane_alu(
        input logic [2:0]       op,
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] d
    );
        logic [CNT_W:0] ext;
        logic [CNT_W:0] res;
        ext = {(CNT_W + 1){1'b0}};
        res = {1'b0, cur};
        case (op)
            3'b010: res = {1'b0, d};
            3'b011: begin
                ext = {1'b0, cur} + {{CNT_W{1'b0}}, 1'b1};
                res = ((SATURATE != 0) && ext[CNT_W]) ? {1'b1, {CNT_W{1'b1}}} : ext;
            end
            3'b100: begin
                ext = {1'b0, cur} - {{CNT_W{1'b0}}, 1'b1};
                res = ((SATURATE != 0) && ext[CNT_W]) ? {1'b1, {CNT_W{1'b0}}} : ext;
            end
            3'b101: begin
                ext = {1'b0, cur} + {1'b0, d};
                res = ((SATURATE != 0) && ext[CNT_W]) ? {1'b1, {CNT_W{1'b1}}} : ext;
            end
            3'b110: res = {(CNT_W + 1){1'b0}};
            3'b111: res = (d > cur) ? {1'b0, d} : {1'b0, cur};
            default: res = {1'b0, cur};
        endcase
        return res;
    endfunction

    logic [CNT_W*LANES-1:0] cnt_r [NUM_SETS];

    logic                   sel_ok_s;
    logic [SEL_W-1:0]       sel_idx_s;
    logic [CNT_W*LANES-1:0] pre_s;
    logic [CNT_W*LANES-1:0] nxt_s;
    logic [CNT_W:0]         alu_s;
    logic [LANES-1:0]       wr_s;
    logic [LANES-1:0]       gsrc_s;
    logic [LANES-1:0]       ovf_s;
    logic [LANES-1:0]       mask_s;

    logic                   s1_nen_r;
    logic [LANES-1:0]       s1_mask_r;
    logic [LANES-1:0]       s1_gsrc_r;
    logic [LANES-1:0]       s1_ovf_r;
    logic [CNT_W*LANES-1:0] s1_pre_r;

    logic [32*LANES-1:0]    data_s;
    logic [31:0]            lane_v_s;
    logic                   unused_data_s;

    // Operand bits above CNT_W are intentionally ignored.
    assign unused_data_s = ^MEM_DATA;

    // Issue-stage decode: set selection, per-lane ALU, write enables, mask and overflow.
    always_comb begin
        sel_ok_s  = ({1'b0, MEM_SEL} < SET_LIMIT);
        sel_idx_s = {SEL_W{1'b0}};
        nxt_s     = {(CNT_W * LANES){1'b0}};
        alu_s     = {(CNT_W + 1){1'b0}};
        wr_s      = {LANES{1'b0}};
        gsrc_s    = {LANES{1'b0}};
        ovf_s     = {LANES{1'b0}};
        mask_s    = {LANES{1'b1}};
        if (sel_ok_s) begin
            sel_idx_s = MEM_SEL;
        end else begin
            sel_idx_s = {SEL_W{1'b0}};
        end
        pre_s = cnt_r[sel_idx_s];
        for (int i = 0; i < LANES; i++) begin
            alu_s = lane_alu(MEM_OP[4*i +: 3], pre_s[CNT_W*i +: CNT_W], MEM_DATA[32*i +: CNT_W]);
            nxt_s[CNT_W*i +: CNT_W] = alu_s[CNT_W-1:0];
            wr_s[i]   = sel_ok_s && (MEM_OP[4*i +: 3] != 3'b000);
            gsrc_s[i] = sel_ok_s && MEM_OP[4*i+3];
            // Only arithmetic ops report carry/borrow; the others leave alu_s[CNT_W] meaningless.
            case (MEM_OP[4*i +: 3])
                3'b011, 3'b100, 3'b101: ovf_s[i] = sel_ok_s && alu_s[CNT_W];
                default:                ovf_s[i] = 1'b0;
            endcase
            mask_s[i] = !(wr_s[i] || gsrc_s[i]);
        end
    end

    // Counter storage: updated at the edge ending the issue cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                cnt_r[s] <= {(CNT_W * LANES){1'b0}};
            end
        end else if (!MEM_nEN) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_s[i]) begin
                    cnt_r[sel_idx_s][CNT_W*i +: CNT_W] <= nxt_s[CNT_W*i +: CNT_W];
                end
            end
        end
    end

    // Stage 1: capture valid, mask, pre-op values, result source and overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_nen_r  <= 1'b1;
            s1_mask_r <= {LANES{1'b1}};
            s1_gsrc_r <= {LANES{1'b0}};
            s1_ovf_r  <= {LANES{1'b0}};
            s1_pre_r  <= {(CNT_W * LANES){1'b0}};
        end else begin
            s1_nen_r <= MEM_nEN;
            if (!MEM_nEN) begin
                s1_mask_r <= mask_s;
                s1_gsrc_r <= gsrc_s;
                s1_ovf_r  <= ovf_s;
                s1_pre_r  <= pre_s;
            end else begin
                s1_mask_r <= {LANES{1'b1}};
                s1_gsrc_r <= {LANES{1'b0}};
                s1_ovf_r  <= {LANES{1'b0}};
            end
        end
    end

    // Stage 2 result mux: masked lanes read 0, GSRC lanes take the live global counter.
    always_comb begin
        data_s   = {(32 * LANES){1'b0}};
        lane_v_s = 32'h0000_0000;
        for (int i = 0; i < LANES; i++) begin
            lane_v_s = 32'h0000_0000;
            if (s1_mask_r[i]) begin
                lane_v_s = 32'h0000_0000;
            end else if (s1_gsrc_r[i]) begin
                lane_v_s[CNT_W-1:0] = GSCs_DATA[CNT_W*i +: CNT_W];
            end else begin
                lane_v_s[CNT_W-1:0] = s1_pre_r[CNT_W*i +: CNT_W];
            end
            data_s[32*i +: 32] = lane_v_s;
        end
    end

    // Stage 2: registered write-back outputs; data holds while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            EW1_nEN  <= 1'b1;
            EW1_MASK <= {LANES{1'b1}};
            EW1_DATA <= {(32 * LANES){1'b0}};
            EW1_OVF  <= {LANES{1'b0}};
        end else begin
            EW1_nEN <= s1_nen_r;
            if (!s1_nen_r) begin
                EW1_MASK <= s1_mask_r;
                EW1_DATA <= data_s;
                EW1_OVF  <= s1_ovf_r;
            end else begin
                EW1_MASK <= {LANES{1'b1}};
                EW1_OVF  <= {LANES{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_mtsp_scs_bank.sv
// Directed bench for mtsp_scs_bank: wrap, saturating and 3-set instances share stimulus
// buses, each with its own valid strobe.
module tb_mtsp_scs_bank;

    logic         clk;
    logic         rst;
    logic         nen_a, nen_b, nen_c;
    logic [1:0]   sel;
    logic [15:0]  op;
    logic [127:0] dat;
    logic [63:0]  gscs;

    logic         a_nen, b_nen, c_nen;
    logic [3:0]   a_mask, b_mask, c_mask;
    logic [127:0] a_data, b_data, c_data;
    logic [3:0]   a_ovf, b_ovf, c_ovf;

    int n_cmp = 0;
    int n_err = 0;

    mtsp_scs_bank #(.NUM_SETS(2), .LANES(4), .CNT_W(16), .SATURATE(0), .SEL_W(1)) dut_a (
        .CLK(clk), .RST(rst), .MEM_nEN(nen_a), .MEM_SEL(sel[0]), .MEM_OP(op),
        .MEM_DATA(dat), .GSCs_DATA(gscs), .EW1_nEN(a_nen), .EW1_MASK(a_mask),
        .EW1_DATA(a_data), .EW1_OVF(a_ovf));

    mtsp_scs_bank #(.NUM_SETS(2), .LANES(4), .CNT_W(16), .SATURATE(1), .SEL_W(1)) dut_b (
        .CLK(clk), .RST(rst), .MEM_nEN(nen_b), .MEM_SEL(sel[0]), .MEM_OP(op),
        .MEM_DATA(dat), .GSCs_DATA(gscs), .EW1_nEN(b_nen), .EW1_MASK(b_mask),
        .EW1_DATA(b_data), .EW1_OVF(b_ovf));

    mtsp_scs_bank #(.NUM_SETS(3), .LANES(4), .CNT_W(16), .SATURATE(0), .SEL_W(2)) dut_c (
        .CLK(clk), .RST(rst), .MEM_nEN(nen_c), .MEM_SEL(sel), .MEM_OP(op),
        .MEM_DATA(dat), .GSCs_DATA(gscs), .EW1_nEN(c_nen), .EW1_MASK(c_mask),
        .EW1_DATA(c_data), .EW1_OVF(c_ovf));

    always #5 clk = ~clk;

    task automatic sample(input int d, output logic n, output logic [3:0] m,
                          output logic [127:0] r, output logic [3:0] v);
        case (d)
            0:       begin n = a_nen; m = a_mask; r = a_data; v = a_ovf; end
            1:       begin n = b_nen; m = b_mask; r = b_data; v = b_ovf; end
            default: begin n = c_nen; m = c_mask; r = c_data; v = c_ovf; end
        endcase
    endtask

    // Issue one instruction at the current cycle and return the outputs seen two cycles later.
    task automatic do_op(input int d, input logic [1:0] s, input logic [15:0] o,
                         input logic [127:0] x, output logic n, output logic [3:0] m,
                         output logic [127:0] r, output logic [3:0] v);
        sel = s; op = o; dat = x;
        case (d)
            0:       nen_a = 1'b0;
            1:       nen_b = 1'b0;
            default: nen_c = 1'b0;
        endcase
        @(posedge clk); #1;
        nen_a = 1'b1; nen_b = 1'b1; nen_c = 1'b1; op = 16'h0000; dat = 128'h0;
        @(posedge clk); #1;
        sample(d, n, m, r, v);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (a_nen !== 1'b1) begin n_err++; $display("FAIL reset_nen got %b exp 1", a_nen); end
        n_cmp++; if (a_mask !== 4'hF) begin n_err++; $display("FAIL reset_mask got %h exp f", a_mask); end
        n_cmp++; if (a_data !== 128'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", a_data); end
        n_cmp++; if (a_ovf !== 4'h0) begin n_err++; $display("FAIL reset_ovf got %h exp 0", a_ovf); end
        n_cmp++; if ({b_nen, c_nen, b_mask, c_mask} !== 10'h3FF) begin n_err++; $display("FAIL reset_bc got %b exp all 1", {b_nen, c_nen, b_mask, c_mask}); end
        rst = 1'b0;
    endtask

    task automatic test_read;
        sel = 2'd0; op = 16'h1111; dat = 128'h0; nen_a = 1'b0;
        @(posedge clk); #1;
        nen_a = 1'b1; op = 16'h0000;
        n_cmp++; if (a_nen !== 1'b1) begin n_err++; $display("FAIL read_t1_nen got %b exp 1", a_nen); end
        @(posedge clk); #1;
        n_cmp++; if (a_nen !== 1'b0) begin n_err++; $display("FAIL read_t2_nen got %b exp 0", a_nen); end
        n_cmp++; if (a_mask !== 4'h0) begin n_err++; $display("FAIL read_t2_mask got %h exp 0", a_mask); end
        n_cmp++; if (a_data !== 128'h0) begin n_err++; $display("FAIL read_t2_data got %h exp 0", a_data); end
        @(posedge clk); #1;
        n_cmp++; if (a_nen !== 1'b1) begin n_err++; $display("FAIL read_t3_nen got %b exp 1", a_nen); end
        n_cmp++; if (a_mask !== 4'hF) begin n_err++; $display("FAIL read_t3_mask got %h exp f", a_mask); end
    endtask

    task automatic test_back_to_back;
        logic n; logic [3:0] m; logic [127:0] r; logic [3:0] v;
        sel = 2'd1; op = 16'h2000; dat = {32'h0000_00FF, 96'h0}; nen_a = 1'b0;
        @(posedge clk); #1;
        op = 16'h3000; dat = 128'h0;
        @(posedge clk); #1;
        op = 16'h1000;
        n_cmp++; if (a_nen !== 1'b0 || a_mask !== 4'b0111) begin n_err++; $display("FAIL b2b_write_ctl got %b/%b exp 0/0111", a_nen, a_mask); end
        n_cmp++; if (a_data !== 128'h0) begin n_err++; $display("FAIL b2b_write_data got %h exp 0", a_data); end
        @(posedge clk); #1;
        nen_a = 1'b1; op = 16'h0000;
        n_cmp++; if (a_data !== {32'h0000_00FF, 96'h0}) begin n_err++; $display("FAIL b2b_inc_data got %h exp X=00ff", a_data); end
        @(posedge clk); #1;
        n_cmp++; if (a_nen !== 1'b0 || a_data !== {32'h0000_0100, 96'h0}) begin n_err++; $display("FAIL b2b_read got %b/%h exp 0/X=0100", a_nen, a_data); end
        @(posedge clk); #1;
        n_cmp++; if (a_nen !== 1'b1) begin n_err++; $display("FAIL b2b_idle_nen got %b exp 1", a_nen); end
        do_op(0, 2'd0, 16'h1000, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0 || m !== 4'b0111) begin n_err++; $display("FAIL b2b_set0_x got %h/%b exp 0/0111", r, m); end
    endtask

    task automatic test_wrap;
        logic n; logic [3:0] m; logic [127:0] r; logic [3:0] v;
        do_op(0, 2'd0, 16'h0002, 128'hFFFF, n, m, r, v);
        do_op(0, 2'd0, 16'h0003, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'hFFFF || v !== 4'b0001) begin n_err++; $display("FAIL wrap_inc got %h/%b exp ffff/0001", r, v); end
        do_op(0, 2'd0, 16'h0001, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0 || v !== 4'b0000) begin n_err++; $display("FAIL wrap_inc_read got %h/%b exp 0/0000", r, v); end
        do_op(0, 2'd0, 16'h0004, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0 || v !== 4'b0001) begin n_err++; $display("FAIL wrap_dec got %h/%b exp 0/0001", r, v); end
        do_op(0, 2'd0, 16'h0001, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'hFFFF) begin n_err++; $display("FAIL wrap_dec_read got %h exp ffff", r); end
        do_op(0, 2'd0, 16'h0005, 128'h3, n, m, r, v);
        n_cmp++; if (r !== 128'hFFFF || v !== 4'b0001) begin n_err++; $display("FAIL wrap_add got %h/%b exp ffff/0001", r, v); end
        do_op(0, 2'd0, 16'h0006, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h2 || v !== 4'b0000) begin n_err++; $display("FAIL wrap_clr got %h/%b exp 2/0000", r, v); end
        do_op(0, 2'd0, 16'h0001, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0) begin n_err++; $display("FAIL wrap_clr_read got %h exp 0", r); end
    endtask

    task automatic test_saturate;
        logic n; logic [3:0] m; logic [127:0] r; logic [3:0] v;
        do_op(1, 2'd0, 16'h0002, 128'hFFFF, n, m, r, v);
        do_op(1, 2'd0, 16'h0003, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'hFFFF || v !== 4'b0001) begin n_err++; $display("FAIL sat_inc got %h/%b exp ffff/0001", r, v); end
        do_op(1, 2'd0, 16'h0001, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'hFFFF || v !== 4'b0000) begin n_err++; $display("FAIL sat_inc_read got %h/%b exp ffff/0000", r, v); end
        do_op(1, 2'd0, 16'h0005, 128'h5, n, m, r, v);
        do_op(1, 2'd0, 16'h0001, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'hFFFF) begin n_err++; $display("FAIL sat_add_read got %h exp ffff", r); end
        do_op(1, 2'd0, 16'h0006, 128'h0, n, m, r, v);
        do_op(1, 2'd0, 16'h0004, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0 || v !== 4'b0001) begin n_err++; $display("FAIL sat_dec got %h/%b exp 0/0001", r, v); end
        do_op(1, 2'd0, 16'h0001, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0) begin n_err++; $display("FAIL sat_dec_read got %h exp 0", r); end
    endtask

    task automatic test_mixed;
        logic n; logic [3:0] m; logic [127:0] r; logic [3:0] v;
        gscs = {16'h1234, 48'h0};
        sel = 2'd0; op = 16'h9070; dat = {64'h0, 32'h5, 32'h0}; nen_a = 1'b0;
        @(posedge clk); #1;
        nen_a = 1'b1; op = 16'h0000; dat = 128'h0;
        @(posedge clk); #1;
        gscs = {16'hBEEF, 48'h0};
        n_cmp++; if (a_mask !== 4'b0101) begin n_err++; $display("FAIL mixed_mask got %b exp 0101", a_mask); end
        n_cmp++; if (a_data !== {32'h0000_1234, 96'h0}) begin n_err++; $display("FAIL mixed_data got %h exp X=1234", a_data); end
        n_cmp++; if (a_ovf !== 4'b0000) begin n_err++; $display("FAIL mixed_ovf got %b exp 0000", a_ovf); end
        do_op(0, 2'd0, 16'h0010, 128'h0, n, m, r, v);
        n_cmp++; if (r !== {64'h0, 32'h5, 32'h0} || m !== 4'b1101) begin n_err++; $display("FAIL mixed_max_read got %h/%b exp Z=5/1101", r, m); end
    endtask

    task automatic test_out_of_range;
        logic n; logic [3:0] m; logic [127:0] r; logic [3:0] v;
        do_op(2, 2'd2, 16'h2222, {4{32'h11}}, n, m, r, v);
        do_op(2, 2'd3, 16'h2222, {4{32'h77}}, n, m, r, v);
        n_cmp++; if (n !== 1'b0 || m !== 4'hF) begin n_err++; $display("FAIL oor_ctl got %b/%h exp 0/f", n, m); end
        n_cmp++; if (r !== 128'h0 || v !== 4'h0) begin n_err++; $display("FAIL oor_data got %h/%h exp 0/0", r, v); end
        do_op(2, 2'd0, 16'h1111, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0) begin n_err++; $display("FAIL oor_set0 got %h exp 0", r); end
        do_op(2, 2'd1, 16'h1111, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0) begin n_err++; $display("FAIL oor_set1 got %h exp 0", r); end
        do_op(2, 2'd2, 16'h1111, 128'h0, n, m, r, v);
        n_cmp++; if (r !== {4{32'h11}}) begin n_err++; $display("FAIL oor_set2 got %h exp 11 per lane", r); end
    endtask

    task automatic test_reset_flush;
        logic n; logic [3:0] m; logic [127:0] r; logic [3:0] v;
        sel = 2'd0; op = 16'h0002; dat = 128'h55; nen_a = 1'b0;
        @(posedge clk); #1;
        nen_a = 1'b1; op = 16'h0000; dat = 128'h0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (a_nen !== 1'b1) begin n_err++; $display("FAIL flush_t2_nen got %b exp 1", a_nen); end
        @(posedge clk); #1;
        n_cmp++; if (a_nen !== 1'b1) begin n_err++; $display("FAIL flush_t3_nen got %b exp 1", a_nen); end
        do_op(0, 2'd0, 16'h1111, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0 || m !== 4'h0) begin n_err++; $display("FAIL flush_set0 got %h/%h exp 0/0", r, m); end
        do_op(0, 2'd1, 16'h1111, 128'h0, n, m, r, v);
        n_cmp++; if (r !== 128'h0) begin n_err++; $display("FAIL flush_set1 got %h exp 0", r); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        nen_a = 1'b1; nen_b = 1'b1; nen_c = 1'b1;
        sel = 2'd0; op = 16'h0000; dat = 128'h0; gscs = 64'h0;
        test_reset();
        test_read();
        test_back_to_back();
        test_wrap();
        test_saturate();
        test_mixed();
        test_out_of_range();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
